// File: rtl/dec_frame_controller.sv
// dec_frame_controller: byte/block glue between the SPI slave and inv_cipher.
// Optional idle-abort of partial frames via DEC_FRAME_TIMEOUT_EN.
module dec_frame_controller #(
    parameter int KEY_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    output logic [127:0]           cipher_text,
    output logic [KEY_BYTES*8-1:0] cipher_key,
    output logic                   start,
    input  logic [127:0]           result,
    input  logic                   result_valid,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   busy
);
    typedef enum logic [1:0] {LOAD_TEXT, LOAD_KEY, RUN, SEND} state_t;
    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] out_buf;
    logic         timeout_hit;
`ifdef DEC_FRAME_TIMEOUT_EN
    logic [15:0] idle;
    logic        counting;
    assign counting    = (state == LOAD_TEXT && cnt != 5'd0) || state == LOAD_KEY || state == SEND;
    assign timeout_hit = counting && !rx_valid && idle == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            idle <= '0;
        else
            idle <= (rx_valid || !counting || timeout_hit) ? 16'd0 : idle + 16'd1;
`else
    assign timeout_hit = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD_TEXT;
            cnt         <= '0;
            out_buf     <= '0;
            tx_byte     <= '0;
            cipher_text <= '0;
            cipher_key  <= '0;
            start       <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            if (timeout_hit) begin
                state   <= LOAD_TEXT;
                cnt     <= '0;
                tx_byte <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    LOAD_TEXT: if (rx_valid) begin
                        cipher_text <= {cipher_text[119:0], rx_byte};
                        busy        <= 1'b1;
                        cnt         <= (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
                        if (cnt == 5'd15) state <= LOAD_KEY;
                    end
                    LOAD_KEY: if (rx_valid) begin
                        cipher_key <= {cipher_key[KEY_BYTES*8-9:0], rx_byte};
                        if (cnt == 5'(KEY_BYTES - 1)) begin
                            cnt   <= '0;
                            state <= RUN;
                            start <= 1'b1;
                        end else
                            cnt <= cnt + 5'd1;
                    end
                    RUN: begin
                        if (rx_valid) overrun <= 1'b1;
                        // the start cycle itself is excluded so a stale held result is not taken
                        if (result_valid && !start) begin
                            out_buf <= result;
                            tx_byte <= result[127:120];
                            state   <= SEND;
                        end
                    end
                    SEND: if (rx_valid) begin
                        if (cnt == 5'd15) begin
                            cnt        <= '0;
                            state      <= LOAD_TEXT;
                            tx_byte    <= '0;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            cnt     <= cnt + 5'd1;
                            tx_byte <= out_buf[119:112];
                            out_buf <= {out_buf[119:0], 8'h00};
                        end
                    end
                    default: state <= LOAD_TEXT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dec_frame_controller.sv
// tb_dec_frame_controller: directed checks on an AES-256 and an AES-128 instance.
module tb_dec_frame_controller;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_valid = 1'b0;
    logic [127:0] result = '0;
    logic         result_valid = 1'b0;
    logic [7:0]   tx_byte, tx_byte16;
    logic [127:0] cipher_text, cipher_text16;
    logic [255:0] cipher_key;
    logic [127:0] cipher_key16;
    logic         start, start16, frame_done, frame_done16, overrun, overrun16, busy, busy16;
    int pass_cnt = 0, total = 0;
    int starts = 0, starts16 = 0, dones = 0;
    logic [7:0] t1_text [16] = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67, 8'h45, 8'hbf,
                                 8'hea, 8'hfc, 8'h49, 8'h90, 8'h4b, 8'h49, 8'h60, 8'h89};
    localparam logic [127:0] T1_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] T1_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start) starts++;
        if (start16) starts16++;
        if (frame_done) dones++;
    end

    dec_frame_controller #(.KEY_BYTES(32), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte),
        .cipher_text(cipher_text), .cipher_key(cipher_key), .start(start), .result(result),
        .result_valid(result_valid), .frame_done(frame_done), .overrun(overrun), .busy(busy));

    dec_frame_controller #(.KEY_BYTES(16), .TIMEOUT_CYCLES(100)) dut16 (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte16),
        .cipher_text(cipher_text16), .cipher_key(cipher_key16), .start(start16), .result(result),
        .result_valid(result_valid), .frame_done(frame_done16), .overrun(overrun16), .busy(busy16));

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_text();
        for (int i = 0; i < 16; i++) send_byte(t1_text[i]);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        result_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, start, overrun, frame_done, tx_byte} !== 12'h000)
            $display("FAIL reset_outputs got busy/start/ovr/done/tx=%h want 000", {busy, start, overrun, frame_done, tx_byte});
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic pulse_result(input logic [127:0] r);
        @(posedge clk); #1;
        result = r;
        result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (cipher_text !== '0 || cipher_key !== '0)
            $display("FAIL reset_regs got ct=%h key=%h want 0", cipher_text, cipher_key);
        else pass_cnt++;
    endtask

    task automatic test_load();
        int s0;
        do_reset();
        s0 = starts;
        send_text();
        total++;
        if (cipher_text !== T1_CT || busy !== 1'b1)
            $display("FAIL t1_text got ct=%h busy=%b want %h busy=1", cipher_text, busy, T1_CT);
        else pass_cnt++;
        for (int i = 0; i < 31; i++) send_byte(8'(i));
        total++;
        if (start !== 1'b0) $display("FAIL t1_early_start got %b want 0", start);
        else pass_cnt++;
        send_byte(8'd31);
        total++;
        if (start !== 1'b1 || cipher_key !== T1_KEY)
            $display("FAIL t1_start got start=%b key=%h want 1 %h", start, cipher_key, T1_KEY);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (start !== 1'b0 || starts - s0 != 1)
            $display("FAIL t1_start_pulse got start=%b pulses=%0d want 0 1", start, starts - s0);
        else pass_cnt++;
    endtask

    task automatic test_result();
        int d0;
        logic [127:0] r;
        d0 = dones;
        r = 128'h00112233445566778899aabbccddeeff;
        pulse_result(r);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (tx_byte !== r[127-8*i -: 8]) $display("FAIL t2_tx%0d got %h want %h", i, tx_byte, r[127-8*i -: 8]);
            else pass_cnt++;
            send_byte(8'ha5);
        end
        total++;
        if (frame_done !== 1'b1 || tx_byte !== 8'h00 || busy !== 1'b0)
            $display("FAIL t2_done got done=%b tx=%h busy=%b want 1 00 0", frame_done, tx_byte, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (frame_done !== 1'b0 || dones - d0 != 1)
            $display("FAIL t2_done_pulse got done=%b pulses=%0d want 0 1", frame_done, dones - d0);
        else pass_cnt++;
    endtask

    task automatic test_key16();
        int s0, s16;
        do_reset();
        s0 = starts;
        s16 = starts16;
        send_text();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        total++;
        if (start16 !== 1'b1 || start !== 1'b0 || cipher_key16 !== 128'h000102030405060708090a0b0c0d0e0f)
            $display("FAIL t3_start16 got s16=%b s32=%b key=%h want 1 0 000102..0f", start16, start, cipher_key16);
        else pass_cnt++;
        for (int i = 16; i < 32; i++) send_byte(8'(i));
        total++;
        if (start !== 1'b1 || start16 !== 1'b0 || overrun16 !== 1'b1)
            $display("FAIL t3_byte48 got s32=%b s16=%b ovr16=%b want 1 0 1", start, start16, overrun16);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (starts16 - s16 != 1 || starts - s0 != 1)
            $display("FAIL t3_pulse_count got s16=%0d s32=%0d want 1 1", starts16 - s16, starts - s0);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int d0;
        logic [127:0] r;
        do_reset();
        send_text();
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        send_byte(8'h77);
        total++;
        if (overrun !== 1'b1 || cipher_key !== T1_KEY)
            $display("FAIL t4_overrun got ovr=%b key=%h want 1 %h", overrun, cipher_key, T1_KEY);
        else pass_cnt++;
        d0 = dones;
        r = 128'h0123456789abcdeffedcba9876543210;
        pulse_result(r);
        total++;
        if (tx_byte !== 8'h01) $display("FAIL t4_first_tx got %h want 01", tx_byte);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (tx_byte !== r[127-8*i -: 8]) $display("FAIL t4_tx%0d got %h want %h", i, tx_byte, r[127-8*i -: 8]);
            else pass_cnt++;
            send_byte(8'h00);
        end
        @(posedge clk); #1;
        total++;
        if (dones - d0 != 1 || overrun !== 1'b1 || busy !== 1'b0)
            $display("FAIL t4_complete got done=%0d ovr=%b busy=%b want 1 1 0", dones - d0, overrun, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int s0;
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(t1_text[i]);
        total++;
        if (busy !== 1'b1) $display("FAIL t5_busy_pre got %b want 1", busy);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || cipher_text !== '0)
            $display("FAIL t5_async got busy=%b ct=%h want 0 0", busy, cipher_text);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL t5_busy_held got %b want 0", busy);
        else pass_cnt++;
        reset = 1'b0;
        s0 = starts;
        send_text();
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        total++;
        if (start !== 1'b1 || cipher_text !== T1_CT || cipher_key !== T1_KEY || overrun !== 1'b0)
            $display("FAIL t5_frame got start=%b ct=%h key=%h ovr=%b", start, cipher_text, cipher_key, overrun);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (starts - s0 != 1) $display("FAIL t5_pulses got %0d want 1", starts - s0);
        else pass_cnt++;
    endtask

`ifdef DEC_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int s0;
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(t1_text[i]);
        repeat (99) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL t6_busy_99 got %b want 1", busy);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || tx_byte !== 8'h00) $display("FAIL t6_abort got busy=%b tx=%h want 0 00", busy, tx_byte);
        else pass_cnt++;
        s0 = starts;
        send_text();
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        total++;
        if (start !== 1'b1 || cipher_text !== T1_CT || cipher_key !== T1_KEY)
            $display("FAIL t6_frame got start=%b ct=%h key=%h", start, cipher_text, cipher_key);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if (starts - s0 != 1) $display("FAIL t6_pulses got %0d want 1", starts - s0);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_result();
        test_key16();
        test_overrun();
        test_reset_midframe();
`ifdef DEC_FRAME_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
